gates_sweep_checker: RTL

Self-contained stimulus-and-check stage wrapped around the basic two-input gate block.
- Upstream role: drives the gate block's a/b inputs through all four input combinations.
- Downstream role: samples the seven gate outputs and compares them against a golden truth table.
- Accumulates an error count and a per-gate sticky failure vector, then reports pass/fail.
- Used as a synthesizable on-chip or in-bench self-check for the gate stage.

---
 rtl/gates_chk_pkg.sv | 24 ++
 rtl/gates_golden_model.sv | 23 ++
 rtl/gates_sweep_checker.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/gates_chk_pkg.sv
// Shared definitions for the gate sweep checker: FSM state encoding,
// gate count and the bit position of each gate in the 7-bit result vectors.
package gates_chk_pkg;

  localparam int NUM_GATES   = 7;
  localparam int NUM_VECTORS = 4;

  localparam int GATE_AND  = 0;
  localparam int GATE_OR   = 1;
  localparam int GATE_NOT  = 2;
  localparam int GATE_NAND = 3;
  localparam int GATE_NOR  = 4;
  localparam int GATE_XOR  = 5;
  localparam int GATE_XNOR = 6;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

endpackage

// File: rtl/gates_golden_model.sv
// Golden truth table for the two-input gate block. Pure combinational;
// output bits follow the err_vec ordering. NOT is taken from input a.
module gates_golden_model
  import gates_chk_pkg::*;
(
  input  logic                 a,
  input  logic                 b,
  output logic [NUM_GATES-1:0] expected
);

  // Reference value of every gate for the current a/b pair
  always_comb begin
    expected            = '0;
    expected[GATE_AND]  = a & b;
    expected[GATE_OR]   = a | b;
    expected[GATE_NOT]  = ~a;
    expected[GATE_NAND] = ~(a & b);
    expected[GATE_NOR]  = ~(a | b);
    expected[GATE_XOR]  = a ^ b;
    expected[GATE_XNOR] = ~(a ^ b);
  end

endmodule

// File: rtl/gates_sweep_checker.sv
// Stimulus-and-check wrapper for the two-input gate block. Sweeps ab through
// 00,01,10,11 for NUM_PASSES passes, compares the seven gate outputs against
// the golden model and accumulates a saturating error count plus a sticky
// per-gate failure vector.
// Optional build macro GATES_SWEEP_FIRST_FAIL_EN adds first_fail_valid and
// first_fail_ab, which capture the ab pair of the first failing vector of a run.
//
//  state  | meaning
//  IDLE   | post-reset, waiting for start
//  DRIVE  | register the next ab vector onto a_o/b_o
//  SETTLE | hold ab for SETTLE_CYCLES cycles (down-counter)
//  CHECK  | compare gate outputs with golden, update counters, advance
//  DONE   | results valid, waiting for a restart
module gates_sweep_checker
  import gates_chk_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int NUM_PASSES    = 1,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             a_o,
  output logic             b_o,
  input  logic             out_and,
  input  logic             out_or,
  input  logic             out_not,
  input  logic             out_nand,
  input  logic             out_nor,
  input  logic             out_xor,
  input  logic             out_xnor,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
`ifdef GATES_SWEEP_FIRST_FAIL_EN
  output logic             first_fail_valid,
  output logic [1:0]       first_fail_ab,
`endif
  output logic [6:0]       err_vec
);

  // Counter widths are floored at one bit so SETTLE_CYCLES of 0/1 and a
  // single pass still elaborate.
  localparam int SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int PASS_W = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
  localparam logic [SET_W-1:0]  SETTLE_LOAD = SET_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [PASS_W-1:0] PASS_LAST   = PASS_W'(NUM_PASSES - 1);

  state_e                state_q, state_d;
  logic                  a_q, a_d;
  logic                  b_q, b_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;
  logic [CNT_W-1:0]      err_count_q, err_count_d;
  logic [NUM_GATES-1:0]  err_vec_q, err_vec_d;
  logic [1:0]            vec_idx_q, vec_idx_d;
  logic [PASS_W-1:0]     pass_idx_q, pass_idx_d;
  logic [SET_W-1:0]      settle_cnt_q, settle_cnt_d;
`ifdef GATES_SWEEP_FIRST_FAIL_EN
  logic                  ff_valid_q, ff_valid_d;
  logic [1:0]            ff_ab_q, ff_ab_d;
`endif

  logic [NUM_GATES-1:0]  expected;
  logic [NUM_GATES-1:0]  sampled;
  logic [NUM_GATES-1:0]  mismatch;

  gates_golden_model u_golden (
    .a        (a_q),
    .b        (b_q),
    .expected (expected)
  );

  // Gather gate outputs in err_vec order and flag the disagreeing bits
  always_comb begin
    sampled            = '0;
    sampled[GATE_AND]  = out_and;
    sampled[GATE_OR]   = out_or;
    sampled[GATE_NOT]  = out_not;
    sampled[GATE_NAND] = out_nand;
    sampled[GATE_NOR]  = out_nor;
    sampled[GATE_XOR]  = out_xor;
    sampled[GATE_XNOR] = out_xnor;
    mismatch           = expected ^ sampled;
  end

  // Sweep sequencing, comparison and result bookkeeping
  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    busy_d       = busy_q;
    done_d       = done_q;
    pass_d       = pass_q;
    err_count_d  = err_count_q;
    err_vec_d    = err_vec_q;
    vec_idx_d    = vec_idx_q;
    pass_idx_d   = pass_idx_q;
    settle_cnt_d = settle_cnt_q;
`ifdef GATES_SWEEP_FIRST_FAIL_EN
    ff_valid_d   = ff_valid_q;
    ff_ab_d      = ff_ab_q;
`endif

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d     = ST_DRIVE;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          err_count_d = '0;
          err_vec_d   = '0;
          vec_idx_d   = 2'd0;
          pass_idx_d  = '0;
`ifdef GATES_SWEEP_FIRST_FAIL_EN
          ff_valid_d  = 1'b0;
          ff_ab_d     = 2'b00;
`endif
        end
      end

      ST_DRIVE: begin
        a_d = vec_idx_q[1];
        b_d = vec_idx_q[0];
        if (SETTLE_CYCLES > 0) begin
          state_d      = ST_SETTLE;
          settle_cnt_d = SETTLE_LOAD;
        end else begin
          state_d = ST_CHECK;
        end
      end

      ST_SETTLE: begin
        if (settle_cnt_q == '0) begin
          state_d = ST_CHECK;
        end else begin
          settle_cnt_d = settle_cnt_q - 1'b1;
        end
      end

      ST_CHECK: begin
        err_vec_d = err_vec_q | mismatch;
        if ((mismatch != '0) && (err_count_q != '1)) begin
          err_count_d = err_count_q + 1'b1;
        end
`ifdef GATES_SWEEP_FIRST_FAIL_EN
        if ((mismatch != '0) && !ff_valid_q) begin
          ff_valid_d = 1'b1;
          ff_ab_d    = {a_q, b_q};
        end
`endif
        if (vec_idx_q != 2'd3) begin
          vec_idx_d = vec_idx_q + 2'd1;
          state_d   = ST_DRIVE;
        end else if (pass_idx_q != PASS_LAST) begin
          vec_idx_d  = 2'd0;
          pass_idx_d = pass_idx_q + PASS_W'(1);
          state_d    = ST_DRIVE;
        end else begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_count_d == '0);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset abandons any run in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      a_q          <= 1'b0;
      b_q          <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_count_q  <= '0;
      err_vec_q    <= '0;
      vec_idx_q    <= 2'd0;
      pass_idx_q   <= '0;
      settle_cnt_q <= '0;
`ifdef GATES_SWEEP_FIRST_FAIL_EN
      ff_valid_q   <= 1'b0;
      ff_ab_q      <= 2'b00;
`endif
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      err_count_q  <= err_count_d;
      err_vec_q    <= err_vec_d;
      vec_idx_q    <= vec_idx_d;
      pass_idx_q   <= pass_idx_d;
      settle_cnt_q <= settle_cnt_d;
`ifdef GATES_SWEEP_FIRST_FAIL_EN
      ff_valid_q   <= ff_valid_d;
      ff_ab_q      <= ff_ab_d;
`endif
    end
  end

  assign a_o       = a_q;
  assign b_o       = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_count_q;
  assign err_vec   = err_vec_q;
`ifdef GATES_SWEEP_FIRST_FAIL_EN
  assign first_fail_valid = ff_valid_q;
  assign first_fail_ab    = ff_ab_q;
`endif

endmodule
